md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port Start  input  1  E-stage multiply/divide instruction valid; sampled at rising edge.
REQ-005 SHALL have port MDOpE  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op.
REQ-006 SHALL have port A  input  32  forwarded rs operand (E stage).
REQ-007 SHALL have port B  input  32  forwarded rt operand (E stage).
REQ-008 SHALL have port Busy  output  1  operation in progress; consumed by controlunit stall logic.
REQ-009 SHALL have port HI  output  32  HI register value.
REQ-010 SHALL have port LO  output  32  LO register value.
REQ-011 SHALL have parameter MULT_CYC, default 5, Busy cycles for MULT/MULTU.
REQ-012 SHALL have parameter DIV_CYC, default 10, Busy cycles for DIV/DIVU.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (Busy=0) and RUN (Busy=1) with a down-counter cnt.
REQ-014 SHALL, in IDLE with Start=1 and MDOpE in 0-3, capture the full result into internal temp registers at that edge, load cnt with MULT_CYC or DIV_CYC, and enter RUN.
REQ-015 SHALL hold Busy=1 for exactly MULT_CYC or DIV_CYC cycles after the capturing edge.
REQ-016 SHALL decrement cnt each RUN cycle; on the edge where cnt reaches 1, commit temp to HI/LO, return to IDLE, and drop Busy on that same edge.
REQ-017 SHALL keep HI/LO unchanged during RUN; new values become visible together with Busy falling.
REQ-018 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned 32x32->64; HI = bits 63:32, LO = bits 31:0.
REQ-019 SHALL compute DIV signed: LO = quotient truncated toward zero, HI = remainder with sign of dividend; DIVU unsigned.
REQ-020 SHALL treat divide-by-zero (B=0) as a normal DIV_CYC-cycle operation that leaves HI and LO unchanged at commit.
REQ-021 SHALL treat signed DIV of 0x80000000 by 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-022 SHALL, in IDLE with Start=1 and MDOpE=4 (MTHI) or 5 (MTLO), write A into HI or LO at that edge, with Busy remaining 0.
REQ-023 SHALL ignore Start (any MDOpE) while in RUN; no restart, no MTHI/MTLO effect.
REQ-024 SHALL ignore Start with MDOpE 6-7.
REQ-025 SHALL drive HI and LO directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set HI=0, LO=0, temp=0, cnt=0, state IDLE, Busy=0.
REQ-027 SHALL give reset priority over Start and abort any in-progress operation without committing.

Structure
REQ-028 SHALL place the MDOpE encodings and the default MULT_CYC/DIV_CYC values in the shared pipeline constants package used by controlunit and datapath.
REQ-029 SHALL be a single module with no sub-module; instantiation inside datapath E stage, with Busy routed to controlunit.

Verification
REQ-030 SHALL cover: MULT A=0xFFFFFFFF B=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-031 SHALL cover: DIV A=0xFFFFFFF9(-7) B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU A=7 B=2 -> LO=3 HI=1.
REQ-032 SHALL cover: HI=0x11, LO=0x22 via MTHI/MTLO, then DIV by B=0 -> Busy 10 cycles, HI=0x11 LO=0x22 unchanged; MTHI causes no Busy.
REQ-033 SHALL cover: Start MULT A=3 B=4 while a DIVU is at cycle 4 of RUN -> ignored; DIVU result committed on schedule; HI/LO not 0/12.
REQ-034 SHALL cover: reset asserted at cycle 3 of MULT with HI/LO previously 0x55/0x66 -> HI=0 LO=0 Busy=0 next cycle; no later commit.

Source files
------------

// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_pkg
// Purpose  : Shared pipeline constants for the multiply/divide unit:
//            MDOpE encodings, default latencies and FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

  // Operation encoding carried on MDOpE (E stage)
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  // Default Busy lengths in cycles
  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  // Width of the latency down-counter
  localparam int CNT_W = 16;

  // Unit control state
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the operations that occupy the unit for several cycles
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage : md_unit_pkg
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : E-stage multiply/divide unit with HI/LO registers. The result is
//            computed at the capturing edge, held in temp registers and
//            committed to HI/LO when the Busy window expires.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,  // Busy cycles for MULT/MULTU (>= 1)
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF    // Busy cycles for DIV/DIVU (>= 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOpE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  md_state_e        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      temp_hi, temp_lo;
  logic [31:0]      hi_reg, lo_reg;

  logic [31:0]        res_hi, res_lo;
  logic [CNT_W-1:0]   res_cyc;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] sa, sb, sq, sr;
  logic [31:0]        div_b;
  logic               accept;

  // An op is accepted only from IDLE; Start is ignored while running
  assign accept = (state == ST_IDLE) && Start && is_long_op(MDOpE);

  // Result datapath: full result of the E-stage operands, computed every cycle
  always_comb begin
    res_hi  = hi_reg;
    res_lo  = lo_reg;
    res_cyc = MULT_LOAD;
    prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u  = {32'd0, A} * {32'd0, B};
    // Divisor forced non-zero so the divider never sees 0; a zero divisor
    // keeps the current HI/LO as its "result" instead.
    div_b   = (B == 32'd0) ? 32'd1 : B;
    sa      = $signed(A);
    sb      = $signed(div_b);
    if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
      sq = $signed(32'h8000_0000);
      sr = '0;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
    end
    case (MDOpE)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        res_cyc = DIV_LOAD;
        if (B != 32'd0) begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      MD_DIVU: begin
        res_cyc = DIV_LOAD;
        if (B != 32'd0) begin
          res_hi = A % div_b;
          res_lo = A / div_b;
        end
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic; leave RUN on the edge where cnt reaches 1
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (cnt <= CNT_W'(1)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // HI/LO, temp and counter: capture, move-to, countdown and commit
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      cnt     <= '0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        temp_hi <= res_hi;
        temp_lo <= res_lo;
        cnt     <= res_cyc;
      end else if (Start && (MDOpE == MD_MTHI)) begin
        hi_reg <= A;
      end else if (Start && (MDOpE == MD_MTLO)) begin
        lo_reg <= A;
      end
    end else begin
      if (cnt <= CNT_W'(1)) begin
        hi_reg <= temp_hi;
        lo_reg <= temp_lo;
        cnt    <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign Busy = (state == ST_RUN);
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule : md_unit
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Self-checking bench for md_unit: table of long operations plus
//            directed sequences for move-to, divide-by-zero, ignored Start
//            and reset abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOpE;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  md_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOpE(MDOpE),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one long op, count Busy samples; also check HI/LO hold during RUN
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt);
    logic [31:0] hi0, lo0;
    hi0 = HI;
    lo0 = LO;
    busy_cnt = 0;
    @(negedge clk);
    Start = 1'b1; MDOpE = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0;
    check("hold_during_run", {HI ^ hi0} | {LO ^ lo0}, 32'd0);
    while (Busy && busy_cnt < 100) begin
      busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    Start = 1'b1; MDOpE = op; A = a; B = 32'h0;
    @(posedge clk); #1;
    Start = 1'b0;
    check("move_busy", {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    int bc;
    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd3, 32'd7,         32'd2,        32'd1,         32'd3,         10};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10};
    vecs[5] = '{3'd0, 32'd3,         32'd4,        32'd0,         32'd12,        5};
    vecs[6] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[7] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10};
    vecs[8] = '{3'd3, 32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, 10};

    reset = 1'b1; Start = 1'b0; MDOpE = 3'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table of long operations
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc);
      check($sformatf("v%0d_busy", i), bc, vecs[i].cyc);
      check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
    end

    // MTHI/MTLO then divide by zero leaves HI/LO alone
    move_to(3'd4, 32'h11);
    check("mthi_hi", HI, 32'h11);
    move_to(3'd5, 32'h22);
    check("mtlo_lo", LO, 32'h22);
    run_op(3'd2, 32'd100, 32'd0, bc);
    check("divz_busy", bc, 10);
    check("divz_hi", HI, 32'h11);
    check("divz_lo", LO, 32'h22);

    // Start MULT 3*4 during DIVU 100/7 is ignored
    bc = 0;
    @(negedge clk);
    Start = 1'b1; MDOpE = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    Start = 1'b0;
    while (Busy && bc < 100) begin
      bc++;
      if (bc == 3) begin
        @(negedge clk);
        Start = 1'b1; MDOpE = 3'd0; A = 32'd3; B = 32'd4;
      end
      @(posedge clk); #1;
      Start = 1'b0;
    end
    check("ign_busy", bc, 10);
    check("ign_hi", HI, 32'd2);
    check("ign_lo", LO, 32'd14);
    @(posedge clk); #1;
    check("ign_no_restart", {31'd0, Busy}, 32'd0);

    // Opcodes 6/7 do nothing
    @(negedge clk);
    Start = 1'b1; MDOpE = 3'd6; A = 32'hDEAD; B = 32'd1;
    @(posedge clk); #1;
    MDOpE = 3'd7;
    @(posedge clk); #1;
    Start = 1'b0;
    check("nop_busy", {31'd0, Busy}, 32'd0);
    check("nop_hi", HI, 32'd2);
    check("nop_lo", LO, 32'd14);

    // Reset during MULT aborts without commit
    move_to(3'd4, 32'h55);
    move_to(3'd5, 32'h66);
    @(negedge clk);
    Start = 1'b1; MDOpE = 3'd0; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    Start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_md_unit
`default_nettype wire
